// File: rtl/vfd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vfd_pkg
// Purpose  : Shared widths, default parameters and state encoding for the
//            VFD soft-start/soft-stop frequency sequencer.
// Revision : 1.0  initial release
// ============================================================================
package vfd_pkg;

   localparam int FREQ_W       = 10;
   localparam int DEF_FMIN     = 1;
   localparam int DEF_FMAX     = 1000;
   localparam int DEF_STEP     = 1;
   localparam int DEF_STEP_DIV = 500000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RAMP_UP = 3'd1,
      ST_RAMP_DN = 3'd2,
      ST_HOLD    = 3'd3,
      ST_STOP    = 3'd4
   } vfd_state_e;

   // States in which the step prescaler runs and freq may change
   function automatic logic is_moving(input vfd_state_e s);
      return (s == ST_RAMP_UP) || (s == ST_RAMP_DN) || (s == ST_STOP);
   endfunction

   function automatic logic is_down(input vfd_state_e s);
      return (s == ST_RAMP_DN) || (s == ST_STOP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vfd_step_tmr.sv
`default_nettype none
// ============================================================================
// Module   : vfd_step_tmr
// Purpose  : Step-rate prescaler; counts 0..STEP_DIV-1 while enabled, pulses
//            o_tick on the terminal count.
// Revision : 1.0  initial release
// ============================================================================
module vfd_step_tmr
   import vfd_pkg::*;
#(
   parameter int STEP_DIV = DEF_STEP_DIV
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);

   localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == c_LAST);
   assign o_tick = i_en & w_last;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr || !i_en || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vfd_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vfd_ramp_ctrl
// Purpose  : Slews the PWM frequency toward an accepted target in fixed steps
//            at a fixed rate. Define VFD_RAMP_SYNC_EN to align each step to a
//            PWM period end (adds the period_done input).
// Revision : 1.0  initial release
// ============================================================================
module vfd_ramp_ctrl
   import vfd_pkg::*;
#(
   parameter int FMIN     = DEF_FMIN,
   parameter int FMAX     = DEF_FMAX,
   parameter int STEP     = DEF_STEP,
   parameter int STEP_DIV = DEF_STEP_DIV
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic [FREQ_W-1:0] tgt_freq,
   input  logic              tgt_vld,
   output logic              tgt_rdy,
   input  logic              estop,
   output logic [FREQ_W-1:0] freq,
   output logic              run_en,
   output logic              busy,
   output logic              at_target
`ifdef VFD_RAMP_SYNC_EN
   ,
   input  logic              period_done
`endif
);

   localparam logic [FREQ_W-1:0]   c_FMIN = FREQ_W'(FMIN);
   localparam logic [FREQ_W-1:0]   c_FMAX = FREQ_W'(FMAX);
   localparam logic signed [FREQ_W:0] c_STEP = (FREQ_W + 1)'(STEP);

   vfd_state_e        r_state, w_state_nxt;
   logic [FREQ_W-1:0] r_freq, w_freq_nxt;
   logic [FREQ_W-1:0] r_tgt, w_tgt_nxt;
   logic              r_run, w_run_nxt;
   logic              r_busy, r_at;
   logic              w_clr, w_tick, w_step;
   logic [FREQ_W-1:0] w_tgt_c, w_up_f, w_dn_f;
   logic signed [FREQ_W:0] w_sum, w_dif, w_tgt_s;

   vfd_step_tmr #(.STEP_DIV(STEP_DIV)) u_step_tmr (
      .clk_sys (clk_sys),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_en    (is_moving(r_state)),
      .o_tick  (w_tick)
   );

`ifdef VFD_RAMP_SYNC_EN
   logic r_pend, w_pend_nxt;

   assign w_step = r_pend & period_done;

   // A tick is remembered until the next PWM period end, unless the ramp is disturbed
   always_comb begin
      w_pend_nxt = r_pend;
      if (estop || tgt_vld || (w_state_nxt != r_state)) begin
         w_pend_nxt = 1'b0;
      end else if (w_tick) begin
         w_pend_nxt = 1'b1;
      end else if (w_step) begin
         w_pend_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_pend <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end
`else
   assign w_step = w_tick;
`endif

   always_comb begin
      w_tgt_c = tgt_freq;
      if (tgt_freq < c_FMIN) begin
         w_tgt_c = c_FMIN;
      end else if (tgt_freq > c_FMAX) begin
         w_tgt_c = c_FMAX;
      end
   end

   // Signed 11-bit step arithmetic so neither direction can wrap past the target
   assign w_sum   = $signed({1'b0, r_freq}) + c_STEP;
   assign w_dif   = $signed({1'b0, r_freq}) - c_STEP;
   assign w_tgt_s = $signed({1'b0, r_tgt});
   assign w_up_f  = (w_sum > w_tgt_s) ? r_tgt : w_sum[FREQ_W-1:0];
   assign w_dn_f  = (w_dif < w_tgt_s) ? r_tgt : w_dif[FREQ_W-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_freq_nxt  = r_freq;
      w_tgt_nxt   = r_tgt;
      w_run_nxt   = r_run;
      w_clr       = 1'b0;
      if (estop) begin
         w_state_nxt = ST_IDLE;
         w_freq_nxt  = c_FMIN;
         w_tgt_nxt   = c_FMIN;
         w_run_nxt   = 1'b0;
         w_clr       = 1'b1;
      end else if (tgt_vld) begin
         if (r_state == ST_IDLE) begin
            if (tgt_freq != '0) begin
               w_run_nxt   = 1'b1;
               w_tgt_nxt   = w_tgt_c;
               w_clr       = 1'b1;
               w_state_nxt = (w_tgt_c == c_FMIN) ? ST_HOLD : ST_RAMP_UP;
            end
         end else begin
            if (tgt_freq == '0) begin
               w_state_nxt = ST_STOP;
               w_tgt_nxt   = c_FMIN;
            end else begin
               w_tgt_nxt = w_tgt_c;
               if (w_tgt_c > r_freq) begin
                  w_state_nxt = ST_RAMP_UP;
               end else if (w_tgt_c < r_freq) begin
                  w_state_nxt = ST_RAMP_DN;
               end else begin
                  w_state_nxt = ST_HOLD;
               end
            end
            // Same-direction retargets keep the step phase
            if ((r_state == ST_HOLD) || (is_down(w_state_nxt) != is_down(r_state))) begin
               w_clr = 1'b1;
            end
         end
      end else if (w_step && is_moving(r_state)) begin
         w_freq_nxt = (r_state == ST_RAMP_UP) ? w_up_f : w_dn_f;
         if (w_freq_nxt == r_tgt) begin
            if (r_state == ST_STOP) begin
               w_state_nxt = ST_IDLE;
               w_run_nxt   = 1'b0;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_freq  <= c_FMIN;
         r_tgt   <= c_FMIN;
         r_run   <= 1'b0;
         r_busy  <= 1'b0;
         r_at    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_freq  <= w_freq_nxt;
         r_tgt   <= w_tgt_nxt;
         r_run   <= w_run_nxt;
         r_busy  <= is_moving(w_state_nxt);
         r_at    <= (w_state_nxt == ST_HOLD);
      end
   end

   assign tgt_rdy   = ~estop;
   assign freq      = r_freq;
   assign run_en    = r_run;
   assign busy      = r_busy;
   assign at_target = r_at;

endmodule
`default_nettype wire

// File: tb/tb_vfd_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vfd_ramp_ctrl
// Purpose  : Self-checking bench for vfd_ramp_ctrl (vector table + scoreboard).
// Revision : 1.0  initial release
// ============================================================================
module tb_vfd_ramp_ctrl;

   logic       clk_sys = 1'b0;
   logic       rst     = 1'b1;
   logic [9:0] tgt_freq = '0;
   logic       tgt_vld = 1'b0;
   logic       estop   = 1'b0;
   logic       tgt_rdy, run_en, busy, at_target;
   logic [9:0] freq;
   logic       period_done = 1'b0;

   logic [9:0] t7_freq = '0;
   logic       t7_vld  = 1'b0;
   logic       t7_rdy, t7_run, t7_busy, t7_at;
   logic [9:0] t7_out;

   always #5 clk_sys = ~clk_sys;

   vfd_ramp_ctrl #(.FMIN(1), .FMAX(1000), .STEP(1), .STEP_DIV(4)) dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .tgt_freq  (tgt_freq),
      .tgt_vld   (tgt_vld),
      .tgt_rdy   (tgt_rdy),
      .estop     (estop),
      .freq      (freq),
      .run_en    (run_en),
      .busy      (busy),
      .at_target (at_target)
`ifdef VFD_RAMP_SYNC_EN
      ,
      .period_done (period_done)
`endif
   );

   vfd_ramp_ctrl #(.FMIN(1), .FMAX(1000), .STEP(7), .STEP_DIV(2)) dut7 (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .tgt_freq  (t7_freq),
      .tgt_vld   (t7_vld),
      .tgt_rdy   (t7_rdy),
      .estop     (1'b0),
      .freq      (t7_out),
      .run_en    (t7_run),
      .busy      (t7_busy),
      .at_target (t7_at)
`ifdef VFD_RAMP_SYNC_EN
      ,
      .period_done (1'b1)
`endif
   );

   typedef struct {
      logic       vld;
      logic [9:0] tgt;
      logic       es;
      int         nw;
      logic [9:0] f;
      logic       run;
      logic       busy;
      logic       at;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic vld, input logic [9:0] tgt, input logic es,
                               input int nw, input logic [9:0] f, input logic run,
                               input logic bsy, input logic at, input logic rdy);
      vec_t v;
      v.vld = vld; v.tgt = tgt; v.es = es; v.nw = nw;
      v.f = f; v.run = run; v.busy = bsy; v.at = at; v.rdy = rdy;
      return v;
   endfunction

   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      @(negedge clk_sys);
      tgt_vld  = v.vld;
      tgt_freq = v.tgt;
      estop    = v.es;
      sb.push_back(v);
      for (int i = 0; i < v.nw; i++) begin
         @(posedge clk_sys);
         #1;
         tgt_vld = 1'b0;
      end
      e = sb.pop_front();
      n_vec++;
      if (freq !== e.f || run_en !== e.run || busy !== e.busy ||
          at_target !== e.at || tgt_rdy !== e.rdy) begin
         n_err++;
         $display("FAIL vec%0d: got freq=%0d run=%b busy=%b at=%b rdy=%b, expected freq=%0d run=%b busy=%b at=%b rdy=%b",
                  idx, freq, run_en, busy, at_target, tgt_rdy, e.f, e.run, e.busy, e.at, e.rdy);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] prev7;
      logic       done7, over7;
      repeat (3) @(negedge clk_sys);
      rst = 1'b0;

`ifdef VFD_RAMP_SYNC_EN
      apply(mk(0, 0, 0, 1, 1, 0, 0, 0, 1), 0);
      apply(mk(1, 5, 0, 1, 1, 1, 1, 0, 1), 1);
      apply(mk(0, 0, 0, 11, 1, 1, 1, 0, 1), 2);
      period_done = 1'b1;
      apply(mk(0, 0, 0, 1, 2, 1, 1, 0, 1), 3);
      period_done = 1'b0;
      apply(mk(0, 0, 0, 4, 2, 1, 1, 0, 1), 4);
`else
      // reset, ramp 1..5, hold
      vecs.push_back(mk(0, 0,  0, 1,  1, 0, 0, 0, 1));
      vecs.push_back(mk(1, 5,  0, 1,  1, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 3,  1, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 1,  2, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 4,  3, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 4,  4, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 4,  5, 1, 0, 1, 1));
      vecs.push_back(mk(0, 0,  0, 10, 5, 1, 0, 1, 1));
      // soft stop 5..1 then idle
      vecs.push_back(mk(1, 0,  0, 1,  5, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 4,  4, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 8,  2, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 3,  2, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 1,  1, 0, 0, 0, 1));
      // reversal at 6 restarts the prescaler
      vecs.push_back(mk(1, 10, 0, 1,  1, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 20, 6, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 2,  6, 1, 1, 0, 1));
      vecs.push_back(mk(1, 3,  0, 1,  6, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 3,  6, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 1,  5, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 4,  4, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 4,  3, 1, 0, 1, 1));
      // same-direction retarget keeps phase; accept beats a coincident tick
      vecs.push_back(mk(1, 8,  0, 1,  3, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 2,  3, 1, 1, 0, 1));
      vecs.push_back(mk(1, 9,  0, 1,  3, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 1,  4, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 3,  4, 1, 1, 0, 1));
      vecs.push_back(mk(1, 9,  0, 1,  4, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 3,  4, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 1,  5, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 8,  7, 1, 1, 0, 1));
      // estop at 7, targets ignored while held
      vecs.push_back(mk(0, 0,  1, 1,  1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5,  1, 3,  1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0,  0, 1,  1, 0, 0, 0, 1));
      // target == FMIN goes straight to HOLD; stop from FMIN; zero in IDLE ignored
      vecs.push_back(mk(1, 1,  0, 1,  1, 1, 0, 1, 1));
      vecs.push_back(mk(1, 0,  0, 1,  1, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0,  0, 4,  1, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0,  0, 2,  1, 0, 0, 0, 1));
      vecs.push_back(mk(1, 9,  0, 6,  2, 1, 1, 0, 1));
      foreach (vecs[i]) apply(vecs[i], i);

      // asynchronous reset mid-ramp takes effect without a clock edge
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (freq !== 10'd1 || run_en !== 1'b0 || busy !== 1'b0 || at_target !== 1'b0) begin
         n_err++;
         $display("FAIL async_rst: got freq=%0d run=%b busy=%b at=%b, expected freq=1 run=0 busy=0 at=0",
                  freq, run_en, busy, at_target);
      end
      @(negedge clk_sys);
      rst = 1'b0;
`endif

      // clamp to FMAX with STEP=7: last step 995 -> 1000, never beyond
      @(negedge clk_sys);
      t7_freq = 10'd1023;
      t7_vld  = 1'b1;
      @(posedge clk_sys);
      #1 t7_vld = 1'b0;
      prev7 = t7_out;
      done7 = 1'b0;
      over7 = 1'b0;
      for (int c = 0; c < 600 && !done7; c++) begin
         @(posedge clk_sys);
         #1;
         if (t7_out > 10'd1000) over7 = 1'b1;
         if (t7_at) done7 = 1'b1;
         else prev7 = t7_out;
      end
      n_vec++;
      if (!done7 || over7 || t7_out !== 10'd1000 || prev7 !== 10'd995) begin
         n_err++;
         $display("FAIL clamp_step7: got done=%b overshoot=%b final=%0d prev=%0d, expected done=1 overshoot=0 final=1000 prev=995",
                  done7, over7, t7_out, prev7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
